// File: rtl/debug_slave_ocimem_ctrl_pkg.sv
// Shared definitions for the debug-slave OCI memory controller: FSM states and jdo field layout.
package debug_slave_ocimem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_J_RD  = 2'd1,
    ST_AV_RD = 2'd2
  } state_t;

  typedef enum logic {
    JK_READ  = 1'b0,
    JK_WRITE = 1'b1
  } jkind_t;

  localparam int JDO_W         = 38;
  localparam int JDO_LDADDR    = 35;
  localparam int JDO_RDREQ     = 34;
  localparam int JDO_CLRERR    = 25;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/debug_slave_ocimem_ram.sv
// Single-port monitor RAM: byte-enabled write, registered read data.
module debug_slave_ocimem_ram #(
  parameter int ADDR_W   = 8,
  parameter     INIT_HEX = ""
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_q
);

  // Image preloading is left to the memory compiler / FPGA flow.
  localparam bit unused_has_init = (INIT_HEX != "");

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/debug_slave_ocimem_ctrl.sv
// Sysclk-side OCI memory controller: decodes JTAG ocimem strobes into a 1-deep command queue and
// shares the monitor RAM with the CPU Avalon-MM debug port (JTAG has priority).
module debug_slave_ocimem_ctrl
  import debug_slave_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter     INIT_HEX = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_mon_a_reg;
  logic [31:0]         r_mon_d_reg;
  logic [31:0]         r_av_readdata;
  logic [31:0]         r_jwdata;
  logic                r_jpend;
  jkind_t              r_jkind;
  logic                r_monitor_ready;
  logic                r_monitor_error;

  logic                w_sel_a, w_sel_b, w_sel_n;
  logic                w_q_req;
  jkind_t              w_q_kind;
  logic                w_jdone;
  logic                w_waitreq;
  logic                w_ram_en, w_ram_we;
  logic [3:0]          w_ram_be;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [31:0]         w_ram_wdata, w_ram_q;
  logic                w_unused_jdo;

  assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Strobes should never coincide; resolve b > a > no_action if they do.
  assign w_sel_b  = take_action_ocimem_b;
  assign w_sel_a  = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_sel_n  = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_q_req  = w_sel_b | (w_sel_a & jdo[JDO_RDREQ]) | w_sel_n;
  assign w_q_kind = w_sel_b ? JK_WRITE : JK_READ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_be    = 4'hF;
    w_ram_addr  = r_mon_a_reg;
    w_ram_wdata = r_jwdata;
    w_jdone     = 1'b0;
    w_waitreq   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (r_jpend) begin
          w_ram_en = 1'b1;
          w_ram_we = (r_jkind == JK_WRITE);
          if (r_jkind == JK_WRITE) w_jdone = 1'b1;
          else                     w_state_nxt = ST_J_RD;
        end else if (av_write) begin
          w_ram_en    = 1'b1;
          w_ram_we    = 1'b1;
          w_ram_be    = av_byteenable;
          w_ram_addr  = av_address;
          w_ram_wdata = av_writedata;
          w_waitreq   = 1'b0;
        end else if (av_read) begin
          w_ram_en    = 1'b1;
          w_ram_addr  = av_address;
          w_state_nxt = ST_AV_RD;
        end
      end
      ST_J_RD: begin
        w_jdone     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_AV_RD: begin
        w_waitreq   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_a_reg     <= '0;
      r_mon_d_reg     <= '0;
      r_av_readdata   <= '0;
      r_jwdata        <= '0;
      r_jpend         <= 1'b0;
      r_jkind         <= JK_READ;
      r_monitor_ready <= 1'b1;
      r_monitor_error <= 1'b0;
    end else begin
      if (w_jdone) begin
        r_mon_a_reg     <= r_mon_a_reg + 1'b1;
        r_jpend         <= 1'b0;
        r_monitor_ready <= 1'b1;
      end
      if (r_state == ST_J_RD)  r_mon_d_reg   <= w_ram_q;
      if (r_state == ST_AV_RD) r_av_readdata <= w_ram_q;
      // An address load wins over a concurrent post-access increment.
      if (w_sel_a && jdo[JDO_LDADDR])
        r_mon_a_reg <= jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
      if (w_sel_a && jdo[JDO_CLRERR]) r_monitor_error <= 1'b0;
      if (w_q_req) begin
        if (r_jpend) begin
          r_monitor_error <= 1'b1;
        end else begin
          r_jpend         <= 1'b1;
          r_jkind         <= w_q_kind;
          r_jwdata        <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          r_monitor_ready <= 1'b0;
        end
      end
    end
  end

  debug_slave_ocimem_ram #(
    .ADDR_W   (ADDR_W),
    .INIT_HEX (INIT_HEX)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en & ~reset),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  // Read data is presented straight from the RAM in the cycle waitrequest drops, then held.
  assign av_readdata    = (r_state == ST_AV_RD) ? w_ram_q : r_av_readdata;
  assign av_waitrequest = w_waitreq | reset;
  assign MonDReg        = r_mon_d_reg;
  assign monitor_ready  = r_monitor_ready;
  assign monitor_error  = r_monitor_error;

endmodule
